// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the HI/LO path: WIDTH-cycle
// shift-add multiply or restoring divide on magnitudes, then a sign fix.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             is_signed;
  logic             sa;
  logic             sb;
  logic             b_zero;
  logic [WIDTH-1:0] opnd;     // multiplicand (multiply) or divisor (divide)
  logic [WIDTH-1:0] acc_hi;   // upper product half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in

  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             borrow;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Handshake: decode holds op_valid/op/src_* until this block is idle;
  // stall tells it the op (or an HI/LO read) cannot proceed this cycle.
  assign busy      = (state != S_IDLE);
  assign stall     = busy & (op_valid | hilo_rd);
  assign state_dbg = state;

  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed & src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag     = (op_signed & src_b[WIDTH-1]) ? -src_b : src_b;

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    rem_sh    = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, rem_sh} - {2'b00, opnd};
    borrow    = div_diff[WIDTH+1];

    prod      = {acc_hi, acc_lo};
    prod_fix  = (is_signed & (sa ^ sb)) ? -prod : prod;
    // A zero divisor leaves quotient all-ones and the remainder equal to |a|;
    // restoring the dividend's sign on the remainder yields hi = src_a.
    quo_fix   = (is_signed & (sa ^ sb) & ~b_zero) ? -acc_lo : acc_lo;
    rem_fix   = (is_signed & sa) ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      b_zero    <= 1'b0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      hilo_we   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid && !flush) begin
            is_div    <= op[1];
            is_signed <= op_signed;
            sa        <= op_signed & src_a[WIDTH-1];
            sb        <= op_signed & src_b[WIDTH-1];
            b_zero    <= (src_b == '0);
            opnd      <= op[1] ? b_mag : a_mag;
            acc_hi    <= '0;
            acc_lo    <= op[1] ? a_mag : b_mag;
            cnt       <= '0;
            state     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= borrow ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], ~borrow};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          if (!flush) begin
            hilo_we <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
